// File: rtl/ternary_pe_mw.sv
// Ternary MAC processing element with a double-buffered weight bank.
// Supports weight-stationary pass-through and output-stationary accumulate/drain modes.
module ternary_pe_mw #(
    parameter  int ACT_BITS = 16,
    parameter  int ACC_BITS = 32,
    parameter  int NUM_W    = 4,
    parameter  bit SATURATE = 1'b1,
    localparam int IW       = $clog2(NUM_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                mode,
    input  logic [IW-1:0]       wsel,
    input  logic                wload_valid,
    input  logic [IW-1:0]       wload_idx,
    input  logic [1:0]          wload_data,
    input  logic                wswap,
    input  logic [ACT_BITS-1:0] act_in,
    output logic [ACT_BITS-1:0] act_out,
    input  logic [ACC_BITS-1:0] psum_in,
    output logic [ACC_BITS-1:0] psum_out,
    input  logic                os_clear,
    input  logic                os_drain,
    output logic                drain_valid,
    output logic                zero_skip,
    output logic                sat_flag,
    output logic [15:0]         skip_count
);

    localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

    logic [1:0]          bank_q [2][NUM_W];
    logic                ptr_q;

    logic [ACT_BITS-1:0] act_q,   act_d;
    logic [ACC_BITS-1:0] psum_q,  psum_d;
    logic [ACC_BITS-1:0] acc_q,   acc_d;
    logic                dv_q,    dv_d;
    logic                sat_q,   sat_d;
    logic [15:0]         skip_q,  skip_d;

    logic [1:0]             w;
    logic signed [ACC_BITS:0] act_ext, prod, base_ext, sum;
    logic                   ovf;
    logic [ACC_BITS-1:0]    res;

    assign w         = bank_q[ptr_q][wsel];
    assign zero_skip = w[0];
    assign act_ext   = {{(ACC_BITS+1-ACT_BITS){act_in[ACT_BITS-1]}}, act_in};

    always_comb begin
        prod = '0;
        case (w)
            2'b10:   prod = act_ext;
            2'b00:   prod = -act_ext;
            default: prod = '0;
        endcase
    end

    // One adder serves both modes: WS adds to psum_in, OS adds to the local accumulator.
    always_comb begin
        base_ext = mode ? {acc_q[ACC_BITS-1], acc_q} : {psum_in[ACC_BITS-1], psum_in};
        sum      = base_ext + prod;
        ovf      = sum[ACC_BITS] ^ sum[ACC_BITS-1];
        res      = sum[ACC_BITS-1:0];
        if (ovf && SATURATE) begin
            res = sum[ACC_BITS] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        act_d  = act_q;
        psum_d = psum_q;
        acc_d  = acc_q;
        dv_d   = 1'b0;
        sat_d  = sat_q;
        skip_d = skip_q;
        if (enable) begin
            act_d = act_in;
            if (zero_skip && skip_q != '1) begin
                skip_d = skip_q + 16'd1;
            end
            if (!mode) begin
                psum_d = res;
                if (ovf) sat_d = 1'b1;
            end else if (os_drain) begin
                psum_d = acc_q;
                dv_d   = 1'b1;
                acc_d  = prod[ACC_BITS-1:0];
            end else begin
                acc_d  = res;
                psum_d = psum_in;
                if (ovf) sat_d = 1'b1;
            end
        end
        // Clear wins over accumulate, but a same-cycle drain still emits the old value.
        if (os_clear) begin
            acc_d  = '0;
            sat_d  = 1'b0;
            skip_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned s = 0; s < NUM_W; s++) begin
                    bank_q[b][s] <= 2'b01;
                end
            end
            ptr_q  <= 1'b0;
            act_q  <= '0;
            psum_q <= '0;
            acc_q  <= '0;
            dv_q   <= 1'b0;
            sat_q  <= 1'b0;
            skip_q <= '0;
        end else begin
            act_q  <= act_d;
            psum_q <= psum_d;
            acc_q  <= acc_d;
            dv_q   <= dv_d;
            sat_q  <= sat_d;
            skip_q <= skip_d;
            if (wload_valid) begin
                bank_q[~ptr_q][wload_idx] <= wload_data;
            end
            if (wswap) begin
                ptr_q <= ~ptr_q;
            end
        end
    end

    assign act_out     = act_q;
    assign psum_out    = psum_q;
    assign drain_valid = dv_q;
    assign sat_flag    = sat_q;
    assign skip_count  = skip_q;

endmodule

// File: tb/tb_ternary_pe_mw.sv
// Randomized and directed bench for ternary_pe_mw; one saturating and one wrapping instance share stimulus.
module tb_ternary_pe_mw;

    localparam int ACT_BITS = 16;
    localparam int ACC_BITS = 32;
    localparam int NUM_W    = 4;
    localparam int IW       = $clog2(NUM_W);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n, enable, mode, wload_valid, wswap, os_clear, os_drain;
    logic [IW-1:0]       wsel, wload_idx;
    logic [1:0]          wload_data;
    logic [ACT_BITS-1:0] act_in;
    logic [ACC_BITS-1:0] psum_in;

    logic [ACT_BITS-1:0] act_out_s, act_out_w;
    logic [ACC_BITS-1:0] psum_out_s, psum_out_w;
    logic                dv_s, dv_w, zs_s, zs_w, sf_s, sf_w;
    logic [15:0]         sk_s, sk_w;

    ternary_pe_mw #(.ACT_BITS(ACT_BITS), .ACC_BITS(ACC_BITS), .NUM_W(NUM_W), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .wsel(wsel),
        .wload_valid(wload_valid), .wload_idx(wload_idx), .wload_data(wload_data), .wswap(wswap),
        .act_in(act_in), .act_out(act_out_s), .psum_in(psum_in), .psum_out(psum_out_s),
        .os_clear(os_clear), .os_drain(os_drain), .drain_valid(dv_s), .zero_skip(zs_s),
        .sat_flag(sf_s), .skip_count(sk_s)
    );

    ternary_pe_mw #(.ACT_BITS(ACT_BITS), .ACC_BITS(ACC_BITS), .NUM_W(NUM_W), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .wsel(wsel),
        .wload_valid(wload_valid), .wload_idx(wload_idx), .wload_data(wload_data), .wswap(wswap),
        .act_in(act_in), .act_out(act_out_w), .psum_in(psum_in), .psum_out(psum_out_w),
        .os_clear(os_clear), .os_drain(os_drain), .drain_valid(dv_w), .zero_skip(zs_w),
        .sat_flag(sf_w), .skip_count(sk_w)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference state: weights held as -1/0/+1 integers, sums as plain longint arithmetic.
    int     m_w [2][NUM_W];
    int     m_ptr;
    longint m_acc [2];
    longint m_po  [2];
    bit     m_sf  [2];
    longint m_ao;
    bit     m_dv;
    int     m_sk;
    bit     m_valid = 1'b0;

    function automatic int decode(input logic [1:0] d);
        if (d == 2'b00) return -1;
        if (d == 2'b10) return 1;
        return 0;
    endfunction

    function automatic longint fix(input longint v, input bit sat, output bit ovf);
        longint mx, mn, span;
        mx   = (longint'(1) <<< (ACC_BITS-1)) - 1;
        mn   = -mx - 1;
        span = longint'(1) <<< ACC_BITS;
        ovf  = (v > mx) || (v < mn);
        if (!ovf) return v;
        if (sat)  return (v > mx) ? mx : mn;
        return (v > mx) ? v - span : v + span;
    endfunction

    task automatic model_update();
        int     w;
        longint p, a, r;
        bit     o;
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int s = 0; s < NUM_W; s++) m_w[b][s] = 0;
            m_ptr = 0;
            for (int k = 0; k < 2; k++) begin
                m_acc[k] = 0; m_po[k] = 0; m_sf[k] = 1'b0;
            end
            m_ao = 0; m_dv = 1'b0; m_sk = 0; m_valid = 1'b1;
            return;
        end
        w = m_w[m_ptr][wsel];
        a = longint'($signed(act_in));
        p = w * a;
        for (int k = 0; k < 2; k++) begin
            if (enable) begin
                if (!mode) begin
                    r = fix(longint'($signed(psum_in)) + p, k == 0, o);
                    m_po[k] = r;
                    if (o) m_sf[k] = 1'b1;
                end else if (os_drain) begin
                    m_po[k]  = m_acc[k];
                    m_acc[k] = p;
                end else begin
                    r = fix(m_acc[k] + p, k == 0, o);
                    m_acc[k] = r;
                    m_po[k]  = longint'($signed(psum_in));
                    if (o) m_sf[k] = 1'b1;
                end
            end
            if (os_clear) begin
                m_acc[k] = 0;
                m_sf[k]  = 1'b0;
            end
        end
        m_dv = enable && mode && os_drain;
        if (enable) begin
            m_ao = a;
            if (w == 0 && m_sk < 65535) m_sk++;
        end
        if (os_clear) m_sk = 0;
        if (wload_valid) m_w[1-m_ptr][wload_idx] = decode(wload_data);
        if (wswap) m_ptr = 1 - m_ptr;
    endtask

    task automatic step();
        #4;
        if (m_valid && rst_n) begin
            check("zero_skip_s", longint'(zs_s), longint'(m_w[m_ptr][wsel] == 0));
            check("zero_skip_w", longint'(zs_w), longint'(m_w[m_ptr][wsel] == 0));
        end
        model_update();
        @(posedge clk);
        #1;
        check("act_out_s",  longint'($signed(act_out_s)),  m_ao);
        check("act_out_w",  longint'($signed(act_out_w)),  m_ao);
        check("psum_out_s", longint'($signed(psum_out_s)), m_po[0]);
        check("psum_out_w", longint'($signed(psum_out_w)), m_po[1]);
        check("drain_s",    longint'(dv_s), longint'(m_dv));
        check("drain_w",    longint'(dv_w), longint'(m_dv));
        check("sat_s",      longint'(sf_s), longint'(m_sf[0]));
        check("sat_w",      longint'(sf_w), longint'(m_sf[1]));
        check("skip_s",     longint'(sk_s), longint'(m_sk));
        check("skip_w",     longint'(sk_w), longint'(m_sk));
    endtask

    task automatic idle();
        rst_n = 1'b1; enable = 1'b0; wload_valid = 1'b0; wswap = 1'b0;
        os_clear = 1'b0; os_drain = 1'b0;
    endtask

    task automatic load_swap(input logic [IW-1:0] idx, input logic [1:0] d);
        idle();
        wload_valid = 1'b1; wload_idx = idx; wload_data = d; wswap = 1'b1;
        step();
    endtask

    int     sk_before;
    longint prev_psum;

    initial begin
        idle();
        mode = 1'b0; wsel = '0; wload_idx = '0; wload_data = 2'b01;
        act_in = '0; psum_in = '0;

        rst_n = 1'b0;
        step();
        check("rst_psum", longint'(psum_out_s), 0);
        check("rst_act",  longint'(act_out_s), 0);
        idle();
        #4;
        check("rst_zero_skip", longint'(zs_s), 1);
        #1;
        @(posedge clk); #1;

        // WS, +1
        load_swap(2'd0, 2'b10);
        idle(); enable = 1'b1; mode = 1'b0; wsel = 2'd0; act_in = 16'd5; psum_in = 32'd100;
        step();
        check("ws_plus", longint'($signed(psum_out_s)), 105);

        // WS, -1
        load_swap(2'd1, 2'b00);
        idle(); enable = 1'b1; wsel = 2'd1; act_in = -16'sd7; psum_in = 32'd3;
        step();
        check("ws_minus", longint'($signed(psum_out_s)), 10);

        // WS, encoding 11
        load_swap(2'd2, 2'b11);
        sk_before = int'(sk_s);
        idle(); enable = 1'b1; wsel = 2'd2; act_in = 16'd9; psum_in = 32'd3;
        step();
        check("ws_zero", longint'($signed(psum_out_s)), 3);
        check("ws_zero_skipcnt", longint'(sk_s), longint'(sk_before + 1));

        // OS accumulate then drain
        load_swap(2'd0, 2'b10);
        idle(); mode = 1'b1; os_clear = 1'b1; wsel = 2'd0;
        step();
        for (int i = 1; i <= 4; i++) begin
            idle(); enable = 1'b1; act_in = ACT_BITS'(i); psum_in = $urandom;
            prev_psum = longint'($signed(psum_in));
            step();
            check("os_pass", longint'($signed(psum_out_s)), prev_psum);
            check("os_pass_dv", longint'(dv_s), 0);
        end
        idle(); enable = 1'b1; os_drain = 1'b1; act_in = '0;
        step();
        check("os_drain", longint'($signed(psum_out_s)), 10);
        check("os_drain_dv", longint'(dv_s), 1);
        idle(); enable = 1'b1; act_in = '0;
        step();
        check("os_drain_dv_once", longint'(dv_s), 0);

        // Overflow
        idle(); enable = 1'b1; mode = 1'b0; wsel = 2'd0; act_in = 16'h0020; psum_in = 32'h7FFF_FFF0;
        step();
        check("sat_val",  longint'(psum_out_s), longint'(32'h7FFF_FFFF));
        check("wrap_val", longint'(psum_out_w), longint'(32'h8000_0010));
        check("sat_flag_s", longint'(sf_s), 1);
        check("sat_flag_w", longint'(sf_w), 1);
        idle(); step(); step();
        check("sat_sticky", longint'(sf_s), 1);
        idle(); os_clear = 1'b1;
        step();
        check("sat_cleared", longint'(sf_s), 0);

        // Double buffer
        load_swap(2'd2, 2'b10);
        idle(); enable = 1'b1; wsel = 2'd2; act_in = 16'd4; psum_in = '0;
        wload_valid = 1'b1; wload_idx = 2'd2; wload_data = 2'b00;
        step();
        check("dbuf_hold", longint'($signed(psum_out_s)), 4);
        idle(); enable = 1'b1; wsel = 2'd2; act_in = 16'd4; psum_in = '0;
        wload_valid = 1'b1; wload_idx = 2'd2; wload_data = 2'b00; wswap = 1'b1;
        step();
        check("dbuf_swap_cycle", longint'($signed(psum_out_s)), 4);
        idle(); enable = 1'b1; wsel = 2'd2; act_in = 16'd4; psum_in = '0;
        step();
        check("dbuf_new", longint'($signed(psum_out_s)), -4);

        // Reset mid-accumulation
        idle(); mode = 1'b1; os_clear = 1'b1;
        step();
        idle(); enable = 1'b1; wsel = 2'd2; act_in = -16'sd50;
        step();
        idle(); rst_n = 1'b0; enable = 1'b1; act_in = 16'd7; psum_in = 32'd7;
        step();
        check("mid_rst_psum", longint'(psum_out_s), 0);
        check("mid_rst_act",  longint'(act_out_s), 0);
        for (int s = 0; s < NUM_W; s++) begin
            idle(); wsel = IW'(s);
            step();
        end
        idle(); enable = 1'b1; mode = 1'b1; os_drain = 1'b1; act_in = 16'd3;
        step();
        check("mid_rst_drain", longint'(psum_out_s), 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst_n       = ($urandom_range(0, 63) != 0);
            enable      = ($urandom_range(0, 3) != 0);
            mode        = 1'($urandom);
            wsel        = IW'($urandom);
            wload_valid = 1'($urandom);
            wload_idx   = IW'($urandom);
            wload_data  = 2'($urandom);
            wswap       = ($urandom_range(0, 3) == 0);
            os_clear    = ($urandom_range(0, 15) == 0);
            os_drain    = ($urandom_range(0, 5) == 0);
            act_in      = ACT_BITS'($urandom);
            case ($urandom_range(0, 3))
                0:       psum_in = $urandom;
                1:       psum_in = 32'h7FFF_0000 + 32'($urandom_range(0, 65535));
                2:       psum_in = 32'h8000_0000 + 32'($urandom_range(0, 65535));
                default: psum_in = 32'($urandom_range(0, 255));
            endcase
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ternary_pe_mw.md
Name: ternary_pe_mw

Overview:
Next-generation integer ternary processing element for the TPU systolic array.
- Weight storage: double-buffered multi-slot ternary weight bank. The shadow bank loads while the active bank computes.
- Modes: runtime-selectable weight-stationary (psum flows north to south) or output-stationary (local accumulate, then drain).
- Status: optional saturating arithmetic and a zero-skip statistics counter.
- Sits in the array grid in place of the single-weight PE. Activations flow west to east; partial sums flow north to south.

Parameters:
- ACT_BITS, 16, signed activation width.
- ACC_BITS, 32, signed accumulator/psum width. Must be greater than ACT_BITS.
- NUM_W, 4, weight slots per bank. Must be a power of 2 and at least 2. IW = $clog2(NUM_W).
- SATURATE, 1, where 1 = clamp on overflow and 0 = two's-complement wrap.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  advance the datapath this cycle.
- mode  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS).
- wsel  in  IW  active-bank slot used for the MAC this cycle.
- wload_valid  in  1  write wload_data into shadow slot wload_idx.
- wload_idx  in  IW  shadow slot index.
- wload_data  in  2  weight encoding: 00 = -1, 01 = 0, 10 = +1, 11 = 0.
- wswap  in  1  exchange the active and shadow banks.
- act_in  in  ACT_BITS  activation from the west.
- act_out  out  ACT_BITS  registered activation to the east.
- psum_in  in  ACC_BITS  partial sum from the north.
- psum_out  out  ACC_BITS  registered partial sum to the south.
- os_clear  in  1  clear the local accumulator, sat_flag and skip_count.
- os_drain  in  1  drain the local accumulator onto psum_out (OS mode).
- drain_valid  out  1  psum_out holds drained accumulator data.
- zero_skip  out  1  combinational: active weight at wsel decodes to 0.
- sat_flag  out  1  sticky: saturation/overflow occurred.
- skip_count  out  16  count of enabled cycles with a zero weight.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - All slots in both banks = 01.
  - Active bank pointer = 0.
  - act_out, psum_out and the accumulator = 0.
  - drain_valid, sat_flag = 0; skip_count = 0.
  - Reset mid-operation discards all state, including in-flight shadow loads.
- Weight bank:
  - wload_valid writes the shadow slot on the edge. This is independent of enable.
  - wswap toggles the bank pointer on the edge, independent of enable. The new weights take effect from the next cycle.
  - wload_valid and wswap in the same cycle: the write lands in the pre-swap shadow bank, which becomes active on that edge. The loaded weight is therefore used next cycle.
- Product: p = +act, 0 or -act per the weight at wsel. act is sign-extended to ACC_BITS + 1 and summed at ACC_BITS + 1 bits.
- Overflow:
  - SATURATE = 1: clamp to +(2^(ACC_BITS-1) - 1) or -2^(ACC_BITS-1).
  - SATURATE = 0: truncate.
  - Either way, overflow sets sat_flag.
- enable = 0: act_out, psum_out and the accumulator hold. drain_valid goes to 0. skip_count holds. Weight writes and swaps still occur.
- WS mode (mode = 0), enable = 1: act_out <= act_in; psum_out <= sat(psum_in + p). Latency 1 cycle. The accumulator is untouched.
- OS mode (mode = 1), enable = 1:
  - act_out <= act_in.
  - No drain: acc <= sat(acc + p); psum_out <= psum_in (pass-through, 1 cycle).
  - os_drain = 1: psum_out <= acc (the pre-update value); drain_valid <= 1 for exactly that cycle; acc <= p.
  - os_drain is ignored in WS mode or when enable = 0.
- os_clear:
  - Effective regardless of enable or mode.
  - acc <= 0, sat_flag <= 0, skip_count <= 0. This overrides the accumulate update in the same cycle.
  - os_clear and os_drain together: the drain outputs the old acc, then acc = 0.
- skip_count: increments when enable = 1 and the weight is zero. Sticks at 0xFFFF.
- A mode change takes effect on the next edge and never clears acc.
- Encoding 11 behaves exactly as 01, including zero_skip = 1.

Test Plan:
- Reset, then check: psum_out = 0, act_out = 0, zero_skip = 1. WS mode, weight +1 in slot 0 loaded and swapped, act_in = 5, psum_in = 100 -> psum_out = 105 one cycle later.
- WS with weight -1, act_in = -7, psum_in = 3 -> psum_out = 10. Weight 11, act_in = 9, psum_in = 3 -> psum_out = 3, zero_skip = 1, skip_count increments by 1.
- OS mode, weight +1, act_in = 1, 2, 3, 4 over 4 enabled cycles, then os_drain -> psum_out = 10, drain_valid high for exactly 1 cycle. On non-drain cycles psum_out equals the prior psum_in.
- ACC_BITS = 32, WS mode, psum_in = 0x7FFFFFF0, act_in = 0x20, weight +1 -> SATURATE = 1 gives psum_out = 0x7FFFFFFF and sat_flag = 1, held until os_clear. SATURATE = 0 gives 0x80000010 and sat_flag = 1.
- Double buffer: active slot 2 = +1, shadow slot 2 written -1 while computing, outputs unchanged. wload and wswap in the same cycle -> the next cycle uses -1 (act_in = 4, psum_in = 0 -> psum_out = -4).
- OS mode, accumulate to 50, then assert rst_n = 0 for 1 cycle -> all outputs 0 and all weights zero. A following drain yields psum_out = 0.
